// File: rtl/tns_link_scheduler_if.sv
//-----------------------------------------------------------------------------
// tns_link_scheduler_if
//
// Purpose : Requester-side handshake bundle of the TNS link scheduler. It
//           carries two independent valid/ready word channels, one per
//           requester, which compete for the single TNS encoder input.
//
// Parameters
//   DATA_W      width of each requester word (TNS encoder datain width)
//
// Signals
//   req0_valid  requester 0 has a word
//   req0_data   requester 0 word
//   req0_ready  requester 0 word accepted at this edge when valid
//   req1_*      same as requester 0, for requester 1
//
// Modports
//   master      requester side: drives valid/data, observes ready
//   slave       scheduler side: observes valid/data, drives ready
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

// Default encoder word width, used when the TNS encoder package has not
// already supplied it.
`ifndef BLEN09_C
`define BLEN09_C 9
`endif

interface tns_link_scheduler_if #(
  parameter int DATA_W = `BLEN09_C
);

  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  modport master (
    output req0_valid, req0_data,
    output req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data,
    input  req1_valid, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/tns_link_scheduler.sv
//-----------------------------------------------------------------------------
// tns_link_scheduler
//
// Purpose : Arbitrates two word streams onto one TNS encoder. After reset it
//           drives SYNC_CYC zero words so the encoder's running r_bit state
//           settles, then grants words with a bounded-burst round-robin
//           policy at up to one word per clock. The granted word is
//           registered onto enc_datain; one cycle later, when the encoder
//           codeout carries that word, link_valid/link_src flag it.
//
// Parameters
//   DATA_W      width of the binary word fed to the encoder
//   MAX_BURST   max consecutive grants to one requester while the other waits
//   SYNC_CYC    zero-data cycles driven after reset
//
// Ports
//   clock       rising-edge clock shared with the TNS encoder
//   reset_n     synchronous active-low reset
//   req         requester handshake bundle (slave modport)
//   enc_datain  registered word driving encoder datain
//   link_valid  encoder codeout holds a granted word this cycle
//   link_src    requester index of the word flagged by link_valid
//   busy        FSM not idle, or a word still in flight
//   stat0_cnt   accepted-word count, requester 0 (TNS_SCHED_STATS_EN only)
//   stat1_cnt   accepted-word count, requester 1 (TNS_SCHED_STATS_EN only)
//
// Build option
//   TNS_SCHED_STATS_EN  when defined, adds the saturating 16-bit per-requester
//                       accepted-word counters and their output ports.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef BLEN09_C
`define BLEN09_C 9
`endif

module tns_link_scheduler #(
  parameter int DATA_W    = `BLEN09_C,
  parameter int MAX_BURST = 4,
  parameter int SYNC_CYC  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  tns_link_scheduler_if.slave req,
  output logic [DATA_W-1:0] enc_datain,
  output logic              link_valid,
  output logic              link_src,
  output logic              busy
`ifdef TNS_SCHED_STATS_EN
  ,
  output logic [15:0]       stat0_cnt,
  output logic [15:0]       stat1_cnt
`endif
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam int SYNC_W  = (SYNC_CYC > 1) ? $clog2(SYNC_CYC) : 1;

  localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_BURST);
  localparam logic [SYNC_W-1:0]  SYNC_LAST  = SYNC_W'(SYNC_CYC - 1);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  state_t              state;
  logic [SYNC_W-1:0]   sync_cnt;
  logic [BURST_W-1:0]  burst_cnt;
  logic                rr_ptr;     // requester favoured on a tie from IDLE
  logic                owner;      // requester granted most recently
  logic                pipe_valid; // word on enc_datain, codeout next cycle
  logic                pipe_src;

  logic                grant;
  logic                xfer;
  logic [DATA_W-1:0]   grant_data;

  //---------------------------------------------------------------------------
  // Grant selection. A lone requester always wins. On a tie the round-robin
  // pointer decides from IDLE; while serving, the current owner keeps the
  // link until its burst reaches MAX_BURST and then must yield.
  //---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default on entry so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = rr_ptr;
    if (req.req0_valid && !req.req1_valid) begin
      grant = 1'b0;
    end else if (!req.req0_valid && req.req1_valid) begin
      grant = 1'b1;
    end else if (req.req0_valid && req.req1_valid) begin
      if (state == ST_SERVE) begin
        grant = (burst_cnt < BURST_MAX) ? owner : ~owner;
      end else begin
        grant = rr_ptr;
      end
    end
  end

  // Ready is offered to the granted requester whenever the link is out of
  // SYNC, so at most one ready is ever high.
  assign req.req0_ready = (state != ST_SYNC) && (grant == 1'b0);
  assign req.req1_ready = (state != ST_SYNC) && (grant == 1'b1);

  assign xfer       = (state != ST_SYNC) &&
                      (grant ? req.req1_valid : req.req0_valid);
  assign grant_data = grant ? req.req1_data : req.req0_data;

  assign busy = (state != ST_IDLE) || pipe_valid || link_valid;

  //---------------------------------------------------------------------------
  // FSM, arbitration state and the two-stage output pipeline.
  // Stage 1 (edge k)  : word lands on enc_datain, pipe_valid marks it.
  // Stage 2 (edge k+1): encoder codeout holds the word, link_valid flags it.
  // enc_datain only changes on a transfer so the encoder input never toggles
  // on idle cycles.
  //---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_SYNC;
      sync_cnt   <= '0;
      burst_cnt  <= '0;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      pipe_valid <= 1'b0;
      pipe_src   <= 1'b0;
      enc_datain <= '0;
      link_valid <= 1'b0;
      link_src   <= 1'b0;
    end else begin
      case (state)
        ST_SYNC: begin
          if (sync_cnt == SYNC_LAST) begin
            state <= ST_IDLE;
          end else begin
            sync_cnt <= sync_cnt + SYNC_W'(1);
          end
        end
        ST_IDLE: begin
          if (xfer) state <= ST_SERVE;
        end
        ST_SERVE: begin
          if (!xfer) state <= ST_IDLE;
        end
        default: state <= ST_SYNC;
      endcase

      pipe_valid <= xfer;
      link_valid <= pipe_valid;
      if (pipe_valid) link_src <= pipe_src;

      if (xfer) begin
        enc_datain <= grant_data;
        pipe_src   <= grant;
        owner      <= grant;
        rr_ptr     <= ~grant;
        // A new burst starts when ownership changes or the link was idle.
        if ((grant != owner) || (state == ST_IDLE)) begin
          burst_cnt <= BURST_W'(1);
        end else if (burst_cnt != BURST_MAX) begin
          burst_cnt <= burst_cnt + BURST_W'(1);
        end
      end else begin
        burst_cnt <= '0;
      end
    end
  end

`ifdef TNS_SCHED_STATS_EN
  //---------------------------------------------------------------------------
  // Per-requester accepted-word counters, saturating at all ones.
  //---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stat0_cnt <= '0;
      stat1_cnt <= '0;
    end else if (xfer) begin
      if (!grant && (stat0_cnt != 16'hFFFF)) stat0_cnt <= stat0_cnt + 16'd1;
      if ( grant && (stat1_cnt != 16'hFFFF)) stat1_cnt <= stat1_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tns_link_scheduler.sv
//-----------------------------------------------------------------------------
// tb_tns_link_scheduler
//
// Directed bench for tns_link_scheduler (DATA_W=9, MAX_BURST=4, SYNC_CYC=2).
// Each accepted word is pushed to a scoreboard as {src, data} when driven;
// when link_valid rises the entry is popped and matched against link_src and
// the word that sat on enc_datain the cycle before.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_tns_link_scheduler;

  localparam int DW = 9;

  typedef struct packed {
    logic          src;
    logic [DW-1:0] data;
  } exp_t;

  logic          clock;
  logic          reset_n;
  logic [DW-1:0] enc_datain;
  logic          link_valid;
  logic          link_src;
  logic          busy;
`ifdef TNS_SCHED_STATS_EN
  logic [15:0]   stat0_cnt;
  logic [15:0]   stat1_cnt;
`endif

  tns_link_scheduler_if #(.DATA_W(DW)) bus ();

  tns_link_scheduler #(
    .DATA_W    (DW),
    .MAX_BURST (4),
    .SYNC_CYC  (2)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (bus),
    .enc_datain (enc_datain),
    .link_valid (link_valid),
    .link_src   (link_src),
    .busy       (busy)
`ifdef TNS_SCHED_STATS_EN
    ,
    .stat0_cnt  (stat0_cnt),
    .stat1_cnt  (stat1_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int            total = 0;
  int            bad   = 0;
  exp_t          sb[$];
  logic [DW-1:0] prev_enc;
  logic [DW-1:0] last_word;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs after every edge: a link_valid pulse must match the oldest entry.
  task automatic monitor();
    exp_t e;
    if (link_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("link_spurious", {31'd0, link_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("link_src", {31'd0, link_src}, {31'd0, e.src});
        check("link_word", {23'd0, prev_enc}, {23'd0, e.data});
      end
    end
  endtask

  // One clock with the current inputs. exp_g = expected granted requester
  // (a transfer is expected), or -1 when no transfer should happen.
  task automatic tick(input int exp_g);
    exp_t e;
    #1;
    if (exp_g >= 0) begin
      check("ready0", {31'd0, bus.req0_ready}, (exp_g == 0) ? 32'd1 : 32'd0);
      check("ready1", {31'd0, bus.req1_ready}, (exp_g == 1) ? 32'd1 : 32'd0);
      e.src  = exp_g[0];
      e.data = (exp_g == 0) ? bus.req0_data : bus.req1_data;
      sb.push_back(e);
      last_word = e.data;
    end
    prev_enc = enc_datain;
    @(posedge clock);
    #1;
    check("enc_datain", {23'd0, enc_datain}, {23'd0, last_word});
    monitor();
  endtask

  // One clock inside SYNC: readies must stay low and zero is driven.
  task automatic sync_tick();
    #1;
    check("sync_ready0", {31'd0, bus.req0_ready}, 32'd0);
    check("sync_ready1", {31'd0, bus.req1_ready}, 32'd0);
    check("sync_enc", {23'd0, enc_datain}, 32'd0);
    check("sync_busy", {31'd0, busy}, 32'd1);
    prev_enc = enc_datain;
    @(posedge clock);
    #1;
    monitor();
  endtask

  // One-cycle reset pulse; in-flight words are dropped from the scoreboard.
  task automatic reset_pulse();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    sb.delete();
    last_word = '0;
    check("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
    check("rst_enc", {23'd0, enc_datain}, 32'd0);
    check("rst_link_valid", {31'd0, link_valid}, 32'd0);
    check("rst_link_src", {31'd0, link_src}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    last_word      = '0;
    prev_enc       = '0;

    // Reset held for two edges, then released with no requests.
    @(posedge clock);
    #1;
    reset_pulse();

    sync_tick();
    sync_tick();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_link_valid", {31'd0, link_valid}, 32'd0);

    // Both valid continuously from IDLE: four grants each, alternating.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.req0_data = DW'(9'h010 + i);
      bus.req1_data = DW'(9'h020 + i);
      tick((i / 4) % 2);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (3) tick(-1);
    check("rr_drain", sb.size(), 32'd0);

    // Owner alone beyond MAX_BURST saturates its burst, so a newly arriving
    // contender is granted at once and then holds for its own full burst.
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.req0_data = DW'(9'h040 + i);
      tick(0);
    end
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req0_data = DW'(9'h060 + i);
      bus.req1_data = DW'(9'h070 + i);
      tick((i < 4) ? 1 : 0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (3) tick(-1);
    check("sat_drain", sb.size(), 32'd0);

    // Requester 0 alone, words 1, 2, 3 back to back.
    bus.req0_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.req0_data = DW'(i);
      tick(0);
    end
    bus.req0_valid = 1'b0;
    repeat (3) tick(-1);
    check("solo_drain", sb.size(), 32'd0);

    // Last grant went to 0, so a tie from IDLE now goes to requester 1.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data  = 9'h0AA;
    bus.req1_data  = 9'h0BB;
    tick(1);
    // Requester 1 sends one more word, then everything goes quiet.
    bus.req0_valid = 1'b0;
    bus.req1_data  = 9'h055;
    tick(1);
    bus.req1_valid = 1'b0;
    repeat (3) tick(-1);
    check("quiet_enc_hold", {23'd0, enc_datain}, 32'h055);
    check("quiet_link_valid", {31'd0, link_valid}, 32'd0);
    check("quiet_busy", {31'd0, busy}, 32'd0);
    check("quiet_drain", sb.size(), 32'd0);

    // Reset for one cycle in the middle of a stream.
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.req0_data = DW'(9'h100 + i);
      tick(0);
    end
    reset_pulse();
    sync_tick();
    sync_tick();
    bus.req0_data = 9'h1FE;
    tick(0);
    bus.req0_valid = 1'b0;
    repeat (3) tick(-1);
    check("post_rst_drain", sb.size(), 32'd0);

`ifdef TNS_SCHED_STATS_EN
    // Counter saturation: far more than 0xFFFF words on requester 0.
    reset_pulse();
    sync_tick();
    sync_tick();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 9'h0C3;
    repeat (70000) @(posedge clock);
    #1;
    bus.req0_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("stat0_sat", {16'd0, stat0_cnt}, 32'h0000FFFF);
    check("stat1_zero", {16'd0, stat1_cnt}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
